// File: rtl/seg7_scan_ctrl.sv
// Eight-digit multiplexed seven-segment controller with CPU-writable value,
// digit-enable and decimal-point registers plus registered read-back.
module seg7_scan_ctrl #(
   parameter int NUM_DIGITS = 8,
   parameter int SCAN_DIV   = 100000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [1:0]            addr,
   input  logic [31:0]           wr_data,
   input  logic                  rd_en,
   output logic [31:0]           rd_data,
   output logic                  rd_valid,
   output logic [NUM_DIGITS-1:0] led_en,
   output logic                  led_ca,
   output logic                  led_cb,
   output logic                  led_cc,
   output logic                  led_cd,
   output logic                  led_ce,
   output logic                  led_cf,
   output logic                  led_cg,
   output logic                  led_dp
);
   localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W = $clog2(NUM_DIGITS);
   localparam int VAL_W = 4 * NUM_DIGITS;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

   typedef enum logic [1:0] {
      A_VALUE  = 2'd0,
      A_DIGEN  = 2'd1,
      A_DPMASK = 2'd2,
      A_RSVD   = 2'd3
   } reg_addr_e;

   logic [VAL_W-1:0]      value_q, value_d;
   logic [NUM_DIGITS-1:0] digen_q, digen_d;
   logic [NUM_DIGITS-1:0] dpmask_q, dpmask_d;
   logic [31:0]           rd_data_q, rd_data_d;
   logic                  rd_valid_q, rd_valid_d;
   logic [CNT_W-1:0]      scan_cnt_q, scan_cnt_d;
   logic [IDX_W-1:0]      digit_idx_q, digit_idx_d;
   logic [NUM_DIGITS-1:0] led_en_q, led_en_d;
   logic [6:0]            seg_q, seg_d;   // {g,f,e,d,c,b,a}, active-low
   logic                  dp_q, dp_d;
   logic [3:0]            nibble;

   // Lit segments for a hex nibble, {g,f,e,d,c,b,a}, active-high.
   function automatic logic [6:0] seg_decode(input logic [3:0] n);
      case (n)
         4'h0: seg_decode = 7'h3F;
         4'h1: seg_decode = 7'h06;
         4'h2: seg_decode = 7'h5B;
         4'h3: seg_decode = 7'h4F;
         4'h4: seg_decode = 7'h66;
         4'h5: seg_decode = 7'h6D;
         4'h6: seg_decode = 7'h7D;
         4'h7: seg_decode = 7'h07;
         4'h8: seg_decode = 7'h7F;
         4'h9: seg_decode = 7'h6F;
         4'hA: seg_decode = 7'h77;
         4'hB: seg_decode = 7'h7C;
         4'hC: seg_decode = 7'h39;
         4'hD: seg_decode = 7'h5E;
         4'hE: seg_decode = 7'h79;
         default: seg_decode = 7'h71;
      endcase
   endfunction

   assign nibble = value_q[{digit_idx_q, 2'b00} +: 4];

   always_comb begin
      value_d     = value_q;
      digen_d     = digen_q;
      dpmask_d    = dpmask_q;
      rd_data_d   = rd_data_q;
      rd_valid_d  = rd_en;
      scan_cnt_d  = scan_cnt_q + CNT_W'(1);
      digit_idx_d = digit_idx_q;
      led_en_d    = '1;
      seg_d       = '1;
      dp_d        = 1'b1;

      if (wr_en) begin
         case (reg_addr_e'(addr))
            A_VALUE:  value_d  = wr_data[VAL_W-1:0];
            A_DIGEN:  digen_d  = wr_data[NUM_DIGITS-1:0];
            A_DPMASK: dpmask_d = wr_data[NUM_DIGITS-1:0];
            default:  ;
         endcase
      end

      // Reads sample the registers before this cycle's write lands.
      if (rd_en) begin
         case (reg_addr_e'(addr))
            A_VALUE:  rd_data_d = 32'(value_q);
            A_DIGEN:  rd_data_d = 32'(digen_q);
            A_DPMASK: rd_data_d = 32'(dpmask_q);
            default:  rd_data_d = '0;
         endcase
      end

      if (scan_cnt_q == CNT_MAX) begin
         scan_cnt_d  = '0;
         digit_idx_d = (digit_idx_q == IDX_MAX) ? '0 : digit_idx_q + IDX_W'(1);
      end

      if (digen_q[digit_idx_q]) begin
         led_en_d = ~(NUM_DIGITS'(1) << digit_idx_q);
         seg_d    = ~seg_decode(nibble);
         dp_d     = ~dpmask_q[digit_idx_q];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value_q     <= '0;
         digen_q     <= '1;
         dpmask_q    <= '0;
         rd_data_q   <= '0;
         rd_valid_q  <= 1'b0;
         scan_cnt_q  <= '0;
         digit_idx_q <= '0;
         led_en_q    <= '1;
         seg_q       <= '1;
         dp_q        <= 1'b1;
      end else begin
         value_q     <= value_d;
         digen_q     <= digen_d;
         dpmask_q    <= dpmask_d;
         rd_data_q   <= rd_data_d;
         rd_valid_q  <= rd_valid_d;
         scan_cnt_q  <= scan_cnt_d;
         digit_idx_q <= digit_idx_d;
         led_en_q    <= led_en_d;
         seg_q       <= seg_d;
         dp_q        <= dp_d;
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign led_en   = led_en_q;
   assign led_ca   = seg_q[0];
   assign led_cb   = seg_q[1];
   assign led_cc   = seg_q[2];
   assign led_cd   = seg_q[3];
   assign led_ce   = seg_q[4];
   assign led_cf   = seg_q[5];
   assign led_cg   = seg_q[6];
   assign led_dp   = dp_q;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with SCAN_DIV = 4: register vectors
// from a table, plus reset, idle-scan and wrap-coincident write sequences.
module tb_seg7_scan_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en, rd_en;
   logic [1:0]  addr;
   logic [31:0] wr_data;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic [7:0]  led_en;
   logic        led_ca, led_cb, led_cc, led_cd, led_ce, led_cf, led_cg, led_dp;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;   // edges since last reset release

   seg7_scan_ctrl #(.NUM_DIGITS(8), .SCAN_DIV(4)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .addr(addr), .wr_data(wr_data),
      .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .led_en(led_en),
      .led_ca(led_ca), .led_cb(led_cb), .led_cc(led_cc), .led_cd(led_cd),
      .led_ce(led_ce), .led_cf(led_cf), .led_cg(led_cg), .led_dp(led_dp)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  addr;
      logic [31:0] wdata;
      int          d;      // digit slot to observe
      logic [7:0]  en;
      logic [6:0]  seg;    // {g..a}, active-low
      logic        dp;
      logic [31:0] rd;
   } vec_t;

   vec_t vecs[10];

   function automatic logic [6:0] segs();
      return {led_cg, led_cf, led_ce, led_cd, led_cc, led_cb, led_ca};
   endfunction

   function automatic int slot(input int c);
      return ((c - 1) / 4) % 8;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_write(input logic [1:0] a, input logic [31:0] d);
      wr_en = 1'b1; addr = a; wr_data = d;
      step();
      wr_en = 1'b0;
   endtask

   task automatic do_read(input string name, input logic [1:0] a, input logic [31:0] exp);
      rd_en = 1'b1; addr = a;
      step();
      rd_en = 1'b0;
      chk({name, "_rd_data"}, rd_data, exp);
      chk({name, "_rd_valid"}, 32'(rd_valid), 32'd1);
   endtask

   task automatic wait_slot(input int d);
      int guard = 0;
      while (slot(cyc) != d && guard < 40) begin
         step();
         guard++;
      end
      if (guard >= 40) chk("wait_slot_timeout", 32'(slot(cyc)), 32'(d));
   endtask

   initial begin
      vecs[0] = '{2'd0, 32'h89ABCDEF, 0, 8'hFE, 7'h0E, 1'b1, 32'h89ABCDEF};
      vecs[1] = '{2'd0, 32'h89ABCDEF, 7, 8'h7F, 7'h00, 1'b1, 32'h89ABCDEF};
      vecs[2] = '{2'd2, 32'h00000004, 2, 8'hFB, 7'h21, 1'b0, 32'h00000004};
      vecs[3] = '{2'd1, 32'h00000005, 1, 8'hFF, 7'h7F, 1'b1, 32'h00000005};
      vecs[4] = '{2'd1, 32'h00000005, 2, 8'hFB, 7'h21, 1'b0, 32'h00000005};
      vecs[5] = '{2'd3, 32'hFFFFFFFF, 0, 8'hFE, 7'h0E, 1'b1, 32'h00000000};
      vecs[6] = '{2'd1, 32'h00000000, 3, 8'hFF, 7'h7F, 1'b1, 32'h00000000};
      vecs[7] = '{2'd1, 32'h000000FF, 5, 8'hDF, 7'h08, 1'b1, 32'h000000FF};
      vecs[8] = '{2'd0, 32'h01234567, 1, 8'hFD, 7'h02, 1'b1, 32'h01234567};
      vecs[9] = '{2'd2, 32'hFFFFFF80, 7, 8'h7F, 7'h40, 1'b0, 32'h00000080};

      rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; addr = 2'd0; wr_data = '0;
      #1;
      chk("rst_led_en", 32'(led_en), 32'hFF);
      chk("rst_seg", 32'(segs()), 32'h7F);
      chk("rst_dp", 32'(led_dp), 32'd1);
      chk("rst_rd_data", rd_data, 32'h0);
      chk("rst_rd_valid", 32'(rd_valid), 32'd0);
      step(); step();
      chk("rst_hold_led_en", 32'(led_en), 32'hFF);
      rst = 1'b0;
      cyc = 0;

      // Idle scan: every digit shows "0", each slot held 4 cycles.
      for (int k = 1; k <= 40; k++) begin
         logic [7:0] exp_en;
         step();
         exp_en = ~(8'd1 << slot(k));
         chk($sformatf("idle_%0d", k), {16'd0, led_en, segs(), led_dp},
             {16'd0, exp_en, 7'h40, 1'b1});
      end

      for (int i = 0; i < 10; i++) begin
         do_write(vecs[i].addr, vecs[i].wdata);
         do_read($sformatf("vec%0d", i), vecs[i].addr, vecs[i].rd);
         step();
         chk($sformatf("vec%0d_rd_valid_drop", i), 32'(rd_valid), 32'd0);
         wait_slot(vecs[i].d);
         chk($sformatf("vec%0d_led_en", i), 32'(led_en), 32'(vecs[i].en));
         chk($sformatf("vec%0d_seg", i), 32'(segs()), 32'(vecs[i].seg));
         chk($sformatf("vec%0d_dp", i), 32'(led_dp), 32'(vecs[i].dp));
      end

      // Reserved address leaves everything alone.
      do_write(2'd3, 32'hFFFFFFFF);
      do_read("rsvd_value", 2'd0, 32'h01234567);
      do_read("rsvd_digen", 2'd1, 32'h000000FF);
      do_read("rsvd_dpmask", 2'd2, 32'h00000080);

      // Write and read together: read returns the old value.
      wr_en = 1'b1; rd_en = 1'b1; addr = 2'd0; wr_data = 32'hDEADBEEF;
      step();
      wr_en = 1'b0; rd_en = 1'b0;
      chk("wr_rd_same_old", rd_data, 32'h01234567);
      chk("wr_rd_same_valid", 32'(rd_valid), 32'd1);
      do_read("wr_rd_same_new", 2'd0, 32'hDEADBEEF);

      // Asynchronous reset mid-cycle while digit 5 is on.
      wait_slot(5);
      chk("pre_rst_led_en", 32'(led_en), 32'hDF);
      #3;
      rst = 1'b1;
      #1;
      chk("async_rst_led_en", 32'(led_en), 32'hFF);
      chk("async_rst_seg", 32'(segs()), 32'h7F);
      chk("async_rst_dp", 32'(led_dp), 32'd1);
      step();
      rst = 1'b0;
      cyc = 0;
      for (int k = 1; k <= 4; k++) begin
         step();
         chk($sformatf("post_rst_d0_%0d", k), 32'(led_en), 32'hFE);
      end
      step();
      chk("post_rst_d1", 32'(led_en), 32'hFD);
      do_read("post_rst_value", 2'd0, 32'h0);
      do_read("post_rst_digen", 2'd1, 32'hFF);

      // Write VALUE on the edge where the scan moves into digit 3.
      begin
         int guard = 0;
         while ((cyc % 32) != 11 && guard < 40) begin
            step();
            guard++;
         end
         if (guard >= 40) chk("wrap_align_timeout", 32'(cyc % 32), 32'd11);
      end
      do_write(2'd0, 32'h00005000);
      chk("wrap_prev_digit", 32'(led_en), 32'hFB);
      for (int k = 0; k < 4; k++) begin
         step();
         chk($sformatf("wrap_d3_en_%0d", k), 32'(led_en), 32'hF7);
         chk($sformatf("wrap_d3_seg_%0d", k), 32'(segs()), 32'h12);
      end
      step();
      chk("wrap_next_digit", 32'(led_en), 32'hEF);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Memory-mapped 8-digit seven-segment display controller sitting on the device side of the system bus, directly downstream of the CPU/bus top level. Holds a 32-bit display value (eight hex nibbles), a digit-enable mask and a decimal-point mask written by the CPU. Time-multiplexes the digits onto the board's shared, active-low segment lines. Supports registered read-back of all control registers.

## Interface

Parameters:
- `NUM_DIGITS`, 8: digits scanned; fixed at 8 for the current board, and the width of `led_en`.
- `SCAN_DIV`, 100000: `clk` cycles each digit is driven. Minimum 2. Counter width is clog2(`SCAN_DIV`).

Ports:
- `clk`  in  1: system clock, the CPU clock domain.
- `rst`  in  1: reset, asynchronous, active-high.
- `wr_en`  in  1: register write strobe, sampled on rising `clk`.
- `addr`  in  2: register select. 0 = VALUE, 1 = DIGEN, 2 = DPMASK, 3 = reserved.
- `wr_data`  in  32: write data.
- `rd_en`  in  1: read strobe.
- `rd_data`  out  32: read data, registered.
- `rd_valid`  out  1: `rd_data` valid pulse.
- `led_en`  out  8: digit enables, active-low, bit i = digit i.
- `led_ca` … `led_cg`  out  1 each: segments a–g, active-low.
- `led_dp`  out  1: decimal point, active-low.

## Operation

Registers and their reset values:
- VALUE[31:0], reset 0x00000000. Digit i shows nibble VALUE[4i+3:4i].
- DIGEN[7:0], reset 0xFF. Only `wr_data[7:0]` is stored; bit i = 0 blanks digit i.
- DPMASK[7:0], reset 0x00. Only `wr_data[7:0]` is stored; bit i = 1 lights the dp of digit i.

Bus writes and reads:
- A write to `addr` = 3 is ignored.
- A read of `addr` = 3 returns 0.
- DIGEN and DPMASK reads are zero-extended.
- `wr_en` and `rd_en` may be asserted together. The read returns the pre-write value.

Scan:
- `scan_cnt` counts 0..`SCAN_DIV`-1 and wraps.
- On wrap, `digit_idx` advances modulo 8 (7 → 0).

Output register, loaded every cycle from the current `digit_idx` = d:
- If DIGEN[d] = 1: `led_en` = ~(1<<d); segments = decoded VALUE nibble d; `led_dp` = ~DPMASK[d].
- If DIGEN[d] = 0: `led_en` = 0xFF; all segments and `led_dp` = 1.
- Exactly one `led_en` bit is low at a time, or none.

Hex decode, listing the lit segments for each nibble:
- 0:abcdef, 1:bc, 2:abdeg, 3:abcdg
- 4:bcfg, 5:acdfg, 6:acdefg, 7:abc
- 8:abcdefg, 9:abcdfg, A:abcefg, b:cdefg
- C:adef, d:bcdeg, E:adefg, F:aefg

## Timing

Reset (asynchronous, takes effect immediately and holds while `rst` = 1):
- `led_en` = 0xFF; `led_ca`..`led_cg` = 1; `led_dp` = 1.
- `rd_data` = 0; `rd_valid` = 0; `scan_cnt` = 0; `digit_idx` = 0.
- On reset mid-scan, the display goes dark in the same cycle. Scan restarts from digit 0 with count 0.

After reset release:
- The first rising edge drives digit 0, so `led_en` = 0xFE.
- Digit 0 holds for `SCAN_DIV` cycles, then digit 1, and so on.
- Full refresh period is 8·`SCAN_DIV` cycles.

Latencies:
- Write: the register updates at edge N. The pins reflect it at edge N+1, if the affected digit is current.
- Read: `rd_data` and `rd_valid` are valid the cycle after the `rd_en` edge. `rd_valid` is a single-cycle pulse per `rd_en` cycle. Back-to-back reads are allowed each cycle.

Boundary cases:
- A write coinciding with a digit change: the new digit shows the new value one cycle later, with no stale-value frame beyond that one cycle.
- DIGEN = 0x00: outputs stay dark while scanning continues.
- Changing DIGEN never stalls or resets `digit_idx`.

## Test plan

All scenarios use `SCAN_DIV` = 4.
- Reset then idle 40 cycles:
  - `led_en` sequences FE, FD, FB, …, 7F, FE, with each value held exactly 4 cycles.
  - Segments show pattern "0" (abcdef low, g high) on every digit.
  - `led_dp` = 1 throughout.
- Write VALUE = 0x89ABCDEF:
  - Digit 0 shows F (a, e, f, g low).
  - Digit 7 shows 8 (all a–g low).
  - Read `addr` 0 → `rd_data` = 0x89ABCDEF with `rd_valid` one cycle later.
- Write DIGEN = 0x05, DPMASK = 0x04:
  - Only digits 0 and 2 ever drive low; digit 2 has `led_dp` = 0.
  - All other digit slots give `led_en` = 0xFF with all segments high.
  - Read back DIGEN → 0x00000005.
- Write and read `addr` 3 with data 0xFFFFFFFF:
  - No register changes.
  - `rd_data` = 0, `rd_valid` = 1.
  - Simultaneous write + read on `addr` 0 returns the old VALUE.
- Assert `rst` asynchronously mid-cycle while digit 5 is active:
  - Outputs go dark immediately (`led_en` = 0xFF), before the next clock edge.
  - After release, digit 0 is active for a full 4 cycles.
  - VALUE = 0, DIGEN = 0xFF.
- Write VALUE on the cycle `scan_cnt` wraps into digit 3:
  - Digit 3 shows the new nibble from the following edge onward.
  - Stale nibble visible for at most 1 cycle.
